// File: rtl/hba_bus_master.sv
// HBA bus initiator: takes single read/write commands on a valid/ready port,
// requests the bus, runs one transfer and returns a one-cycle response.
module hba_bus_master #(
   parameter int DBUS_WIDTH        = 8,
   parameter int PERIPH_ADDR_WIDTH = 4,
   parameter int REG_ADDR_WIDTH    = 8,
   parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES    = 255
) (
   input  logic                  hba_clk,
   input  logic                  hba_reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_rnw,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DBUS_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DBUS_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_timeout,
   output logic                  hba_mrequest,
   input  logic                  hba_mgrant,
   output logic [ADDR_WIDTH-1:0] hba_abus_master,
   output logic                  hba_rnw_master,
   output logic                  hba_select_master,
   output logic [DBUS_WIDTH-1:0] hba_dbus_master,
   input  logic                  hba_xferack,
   input  logic [DBUS_WIDTH-1:0] hba_dbus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_XFER = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   // Wide enough to hold TIMEOUT_CYCLES, and at least one bit when disabled.
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  cmd_rnw_q, cmd_rnw_d;
   logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [DBUS_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DBUS_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic                  mrequest_q, mrequest_d;
   logic [ADDR_WIDTH-1:0] abus_q, abus_d;
   logic                  rnw_m_q, rnw_m_d;
   logic                  select_q, select_d;
   logic [DBUS_WIDTH-1:0] dbus_m_q, dbus_m_d;
   logic                  timeout_hit;

   // True in the last permitted select cycle; xferack in that cycle still wins.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                        ((int'(cnt_q) + 1) == TIMEOUT_CYCLES);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cmd_rnw_d     = cmd_rnw_q;
      cmd_addr_d    = cmd_addr_q;
      cmd_wdata_d   = cmd_wdata_q;
      cmd_ready_d   = cmd_ready_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b0;
      mrequest_d    = mrequest_q;
      abus_d        = abus_q;
      rnw_m_d       = rnw_m_q;
      select_d      = select_q;
      dbus_m_d      = dbus_m_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               cmd_rnw_d   = cmd_rnw;
               cmd_addr_d  = cmd_addr;
               cmd_wdata_d = cmd_wdata;
               cmd_ready_d = 1'b0;
               mrequest_d  = 1'b1;
               state_d     = ST_REQ;
            end
         end

         ST_REQ: begin
            if (hba_mgrant) begin
               select_d = 1'b1;
               abus_d   = cmd_addr_q;
               rnw_m_d  = cmd_rnw_q;
               dbus_m_d = cmd_rnw_q ? '0 : cmd_wdata_q;
               cnt_d    = '0;
               state_d  = ST_XFER;
            end
         end

         ST_XFER: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (hba_xferack || timeout_hit) begin
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = !hba_xferack;
               rsp_rdata_d   = (hba_xferack && cmd_rnw_q) ? hba_dbus : '0;
               mrequest_d    = 1'b0;
               select_d      = 1'b0;
               abus_d        = '0;
               rnw_m_d       = 1'b0;
               dbus_m_d      = '0;
               state_d       = ST_RESP;
            end
         end

         default: begin
            cnt_d       = '0;
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge hba_clk) begin
      if (hba_reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         cmd_rnw_q     <= 1'b0;
         cmd_addr_q    <= '0;
         cmd_wdata_q   <= '0;
         cmd_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_timeout_q <= 1'b0;
         mrequest_q    <= 1'b0;
         abus_q        <= '0;
         rnw_m_q       <= 1'b0;
         select_q      <= 1'b0;
         dbus_m_q      <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cmd_rnw_q     <= cmd_rnw_d;
         cmd_addr_q    <= cmd_addr_d;
         cmd_wdata_q   <= cmd_wdata_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_timeout_q <= rsp_timeout_d;
         mrequest_q    <= mrequest_d;
         abus_q        <= abus_d;
         rnw_m_q       <= rnw_m_d;
         select_q      <= select_d;
         dbus_m_q      <= dbus_m_d;
      end
   end

   assign cmd_ready         = cmd_ready_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_rdata         = rsp_rdata_q;
   assign rsp_timeout       = rsp_timeout_q;
   assign hba_mrequest      = mrequest_q;
   assign hba_abus_master   = abus_q;
   assign hba_rnw_master    = rnw_m_q;
   assign hba_select_master = select_q;
   assign hba_dbus_master   = dbus_m_q;

endmodule

// File: tb/tb_hba_bus_master.sv
// Directed bench for hba_bus_master: write, read, grant delay, timeout,
// busy pokes, back-to-back commands and reset during a transfer.
module tb_hba_bus_master;

   logic        hba_clk = 1'b0;
   logic        hba_reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_rnw;
   logic [11:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_timeout;
   logic        hba_mrequest;
   logic        hba_mgrant;
   logic [11:0] hba_abus_master;
   logic        hba_rnw_master;
   logic        hba_select_master;
   logic [7:0]  hba_dbus_master;
   logic        hba_xferack;
   logic [7:0]  hba_dbus;

   int errors = 0;
   int checks = 0;

   hba_bus_master #(
      .DBUS_WIDTH(8), .PERIPH_ADDR_WIDTH(4), .REG_ADDR_WIDTH(8),
      .ADDR_WIDTH(12), .TIMEOUT_CYCLES(8)
   ) dut (
      .hba_clk(hba_clk), .hba_reset(hba_reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .hba_mrequest(hba_mrequest), .hba_mgrant(hba_mgrant),
      .hba_abus_master(hba_abus_master), .hba_rnw_master(hba_rnw_master),
      .hba_select_master(hba_select_master), .hba_dbus_master(hba_dbus_master),
      .hba_xferack(hba_xferack), .hba_dbus(hba_dbus)
   );

   always #5 hba_clk = ~hba_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after RESP.
   task automatic applyStimulus(input logic rnw, input logic [11:0] addr,
                                input logic [7:0] wdata, input int grantDelay,
                                input int ackCycle, input logic [7:0] slaveData,
                                input int expSel, input logic expTimeout,
                                input logic [7:0] expRdata, input logic busyPoke);
      int selCycles;
      checkOutput("readyAtStart", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wdata;
      hba_mgrant = 1'b0;
      @(negedge hba_clk);
      if (busyPoke) begin
         cmd_addr = 12'hFFF; cmd_wdata = 8'hEE; cmd_rnw = ~rnw;
      end else begin
         cmd_valid = 1'b0;
      end
      checkOutput("reqReady", cmd_ready, 0);
      checkOutput("reqMreq", hba_mrequest, 1);
      for (int g = 0; g < grantDelay; g++) begin
         checkOutput("waitSel", hba_select_master, 0);
         checkOutput("waitMreq", hba_mrequest, 1);
         if (g == 3) begin
            hba_mgrant = 1'b1; #2; hba_mgrant = 1'b0;
         end
         @(negedge hba_clk);
      end
      hba_mgrant = 1'b1;
      @(negedge hba_clk);
      hba_mgrant = 1'b0;
      selCycles = 0;
      while (hba_select_master === 1'b1 && selCycles < 50) begin
         selCycles++;
         checkOutput("xferAbus", hba_abus_master, addr);
         checkOutput("xferRnw", hba_rnw_master, rnw);
         checkOutput("xferDbus", hba_dbus_master, rnw ? 8'h00 : wdata);
         checkOutput("xferMreq", hba_mrequest, 1);
         checkOutput("xferNoRsp", rsp_valid, 0);
         if (selCycles == ackCycle) begin
            hba_xferack = 1'b1; hba_dbus = slaveData;
         end
         @(negedge hba_clk);
         hba_xferack = 1'b0; hba_dbus = 8'h5A;
      end
      checkOutput("selCycles", selCycles, expSel);
      checkOutput("rspValid", rsp_valid, 1);
      checkOutput("rspTimeout", rsp_timeout, expTimeout);
      checkOutput("rspRdata", rsp_rdata, expRdata);
      checkOutput("rspBusIdle", {hba_select_master, hba_rnw_master, hba_mrequest,
                                 hba_abus_master, hba_dbus_master}, 0);
      checkOutput("rspReady", cmd_ready, 0);
      // Late ack in RESP must be ignored.
      hba_xferack = 1'b1;
      @(negedge hba_clk);
      hba_xferack = 1'b0;
      cmd_valid = 1'b0;
      checkOutput("doneValid", rsp_valid, 0);
      checkOutput("doneReady", cmd_ready, 1);
      checkOutput("doneRdata", rsp_rdata, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      hba_reset = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; hba_mgrant = 1'b0; hba_xferack = 1'b0; hba_dbus = 8'h5A;
      repeat (3) @(negedge hba_clk);
      checkOutput("rstReady", cmd_ready, 1);
      checkOutput("rstOutputs", {rsp_valid, rsp_timeout, rsp_rdata, hba_mrequest,
                                 hba_select_master, hba_rnw_master,
                                 hba_abus_master, hba_dbus_master}, 0);
      hba_reset = 1'b0;
      @(negedge hba_clk);

      $display("[TB] write 0x105 <= 0xA5");
      applyStimulus(1'b0, 12'h105, 8'hA5, 0, 2, 8'h77, 2, 1'b0, 8'h00, 1'b0);
      $display("[TB] read 0x201, ack on 3rd select cycle");
      applyStimulus(1'b1, 12'h201, 8'h99, 0, 3, 8'h3C, 3, 1'b0, 8'h3C, 1'b0);
      $display("[TB] grant delayed 10 cycles with a short glitch");
      applyStimulus(1'b0, 12'h3F0, 8'h12, 10, 1, 8'h00, 1, 1'b0, 8'h00, 1'b0);
      $display("[TB] timeout with no ack");
      applyStimulus(1'b1, 12'h444, 8'h00, 0, 0, 8'h00, 8, 1'b1, 8'h00, 1'b0);
      $display("[TB] ack on the timeout cycle");
      applyStimulus(1'b1, 12'h555, 8'h00, 0, 8, 8'hC3, 8, 1'b0, 8'hC3, 1'b0);
      $display("[TB] busy pokes then back-to-back command");
      applyStimulus(1'b0, 12'h123, 8'h34, 2, 2, 8'h00, 2, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 12'h0AB, 8'h00, 0, 1, 8'h81, 1, 1'b0, 8'h81, 1'b0);
      @(negedge hba_clk);
      checkOutput("idleNoReq", hba_mrequest, 0);
      checkOutput("idleNoSel", hba_select_master, 0);

      $display("[TB] reset during transfer");
      cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 12'h333; cmd_wdata = 8'h11;
      hba_mgrant = 1'b1;
      @(negedge hba_clk);
      cmd_valid = 1'b0;
      @(negedge hba_clk);
      checkOutput("preRstSel", hba_select_master, 1);
      hba_reset = 1'b1;
      @(negedge hba_clk);
      hba_reset = 1'b0; hba_mgrant = 1'b0;
      checkOutput("rstMidReady", cmd_ready, 1);
      checkOutput("rstMidBus", {rsp_valid, hba_mrequest, hba_select_master,
                                hba_rnw_master, hba_abus_master, hba_dbus_master}, 0);
      @(negedge hba_clk);
      checkOutput("rstMidNoRsp", rsp_valid, 0);
      checkOutput("rstMidNoSel", hba_select_master, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hba_bus_master.md
Name: hba_bus_master

Overview:
- Generic HBA bus initiator: accepts single read/write commands on a local valid/ready interface, arbitrates for the bus, runs one HBA transfer, and returns a response.
- Occupies one master slot (1..3) alongside serial_fpga. Its outputs feed the master OR tree; it requests the bus through the arbiter.
- Reusable front end for future on-chip masters such as sequencers and soft CPUs.

Parameters:
- DBUS_WIDTH, 8, data bus width.
- PERIPH_ADDR_WIDTH, 4, peripheral slot field width.
- REG_ADDR_WIDTH, 8, register field width.
- ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, full address width.
- TIMEOUT_CYCLES, 255, maximum cycles select may stay high without xferack; 0 disables the timeout.

Ports:
- hba_clk  in  1  clock.
- hba_reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_rnw  in  1  1=read, 0=write.
- cmd_addr  in  ADDR_WIDTH  target {slot, register}.
- cmd_wdata  in  DBUS_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DBUS_WIDTH  read data (0 for writes or timeout).
- rsp_timeout  out  1  qualifies rsp_valid; transfer aborted.
- hba_mrequest  out  1  bus request to arbiter.
- hba_mgrant  in  1  grant from arbiter.
- hba_abus_master  out  ADDR_WIDTH  address; 0 when inactive.
- hba_rnw_master  out  1  0 when inactive.
- hba_select_master  out  1  transfer in progress.
- hba_dbus_master  out  DBUS_WIDTH  write data; 0 when inactive and during reads.
- hba_xferack  in  1  combined slave acknowledge.
- hba_dbus  in  DBUS_WIDTH  combined bus data (read data source).

Behaviour:
- Clock and reset: one clock, hba_clk. hba_reset is synchronous and active-high.
- Reset values: all outputs 0 except cmd_ready=1; state IDLE; timeout counter 0. Reset mid-transfer drops select and mrequest at the next edge and produces no response.
- All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch rnw/addr/wdata and go to REQ. hba_mrequest=1 from the next cycle.
- REQ:
  - cmd_ready=0, hold mrequest.
  - When hba_mgrant is sampled 1, go to XFER. From the next cycle: select=1, abus=addr, rnw_master=rnw, dbus_master = wdata for a write, 0 for a read.
  - A grant that drops before it is sampled is ignored; keep waiting.
- XFER:
  - Hold all bus outputs stable. The counter increments each cycle.
  - When hba_xferack is sampled 1: capture hba_dbus into rsp_rdata for a read, 0 for a write. Go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no xferack (and TIMEOUT_CYCLES≠0): go to RESP with timeout flag set and rdata=0.
  - xferack in the same cycle as the timeout: xferack wins, no timeout.
  - hba_mgrant is ignored in XFER.
- RESP (one cycle):
  - select, abus, rnw_master, dbus_master and mrequest are all 0.
  - rsp_valid=1 and rsp_timeout is set as appropriate. Clear the counter.
  - Next state IDLE; cmd_ready=1 in the following cycle.
- Latency, no contention: cmd accepted at T; mrequest at T+1; grant sampled at T+1 gives select at T+2; xferack at T+2 gives rsp_valid at T+3; cmd_ready at T+4. Minimum 4 cycles per command.
- cmd_valid while not in IDLE is not accepted; inputs are don't-care.
- A late xferack after a timeout, seen in RESP or IDLE, is ignored.

Test Plan:
- Write: cmd addr=0x105, wdata=0xA5, grant immediate, slave ack 1 cycle after select -> abus=0x105, rnw=0, dbus_master=0xA5 for exactly 2 cycles; rsp_valid 1 cycle, rsp_rdata=0, rsp_timeout=0; bus outputs return to 0.
- Read: cmd addr=0x201, slave drives hba_dbus=0x3C with xferack on the 3rd select cycle -> dbus_master=0 throughout; rsp_rdata=0x3C.
- Grant delay: hold mgrant=0 for 10 cycles after mrequest -> select stays 0; mrequest stays 1; transfer starts the cycle after grant.
- Timeout: TIMEOUT_CYCLES=8, no xferack -> select high 8 cycles then drops; rsp_valid=1, rsp_timeout=1, rsp_rdata=0. Separately, xferack on the timeout cycle -> rsp_timeout=0.
- Busy: pulse cmd_valid during REQ, XFER and RESP -> no second transfer; back-to-back commands are accepted only when cmd_ready=1, with ≥4-cycle spacing.
- Reset mid-XFER: assert hba_reset while select=1 -> next edge select, mrequest and bus outputs are 0, cmd_ready=1, no rsp_valid.
